// File: rtl/tcm_arbiter.sv
//-----------------------------------------------------------------------------
// tcm_arbiter
//
// Arbitrates an instruction port (ibus) and a data port (dbus) onto a single
// tightly-coupled memory. One access is in flight at a time:
//   IDLE  : pick a winner, latch its request fields
//   ISSUE : present the request to the TCM for exactly one cycle
//   WAIT  : hold until the TCM acks, then forward the ack to the winner
//
// dbus wins simultaneous requests. A starvation counter tracks consecutive
// dbus wins taken while ibus was waiting. Once it reaches STARVE_LIMIT, ibus
// wins the next arbitration.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_ibus_req/addr         instruction read request
//   o_ibus_ack              instruction completion (one cycle)
//   i_dbus_req/addr/sel/
//     write/data            data read/write request
//   o_dbus_ack              data completion (one cycle)
//   o_rdata                 shared read data (= i_tcm_data)
//   o_dev_sel/addr/sel/
//     write/wdata           TCM request bus, non-zero only in ISSUE
//   i_tcm_ack, i_tcm_data   TCM response
//   o_busy                  high outside IDLE
//-----------------------------------------------------------------------------
module tcm_arbiter #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,

  input  logic                      i_ibus_req,
  input  logic [MEM_ADDR_WIDTH+1:2] i_ibus_addr,
  output logic                      o_ibus_ack,

  input  logic                      i_dbus_req,
  input  logic [MEM_ADDR_WIDTH+1:2] i_dbus_addr,
  input  logic [3:0]                i_dbus_sel,
  input  logic                      i_dbus_write,
  input  logic [31:0]               i_dbus_data,
  output logic                      o_dbus_ack,

  output logic [31:0]               o_rdata,

  output logic                      o_dev_sel,
  output logic [MEM_ADDR_WIDTH+1:2] o_addr,
  output logic [3:0]                o_sel,
  output logic                      o_write,
  output logic [31:0]               o_wdata,
  input  logic                      i_tcm_ack,
  input  logic [31:0]               i_tcm_data,

  output logic                      o_busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_grant;        // 0 = ibus, 1 = dbus
  logic                      w_next_grant;
  logic [CNT_W-1:0]          r_starve;
  logic [CNT_W-1:0]          w_next_starve;

  // Winner's request fields, captured when the grant is decided so the
  // access completes intact even if the requester drops or changes inputs.
  logic [MEM_ADDR_WIDTH+1:2] r_addr;
  logic [3:0]                r_sel;
  logic                      r_write;
  logic [31:0]               r_wdata;

  logic                      w_capture;
  logic                      w_starve_hit;
  logic                      w_pick_dbus;
  logic                      w_active;
  logic                      w_issue;

  assign w_starve_hit = (r_starve == CNT_W'(STARVE_LIMIT));
  assign w_pick_dbus  = i_dbus_req && !(i_ibus_req && w_starve_hit);

  //---------------------------------------------------------------------------
  // Next-state / arbitration
  //---------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_next_grant  = r_grant;
    w_next_starve = r_starve;
    w_capture     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!i_ibus_req) begin
          w_next_starve = '0;
        end
        if (i_ibus_req || i_dbus_req) begin
          w_next_grant = w_pick_dbus;
          w_next_state = ST_ISSUE;
          w_capture    = 1'b1;
          if (w_pick_dbus) begin
            if (i_ibus_req && !w_starve_hit) begin
              w_next_starve = r_starve + CNT_W'(1);
            end
          end else begin
            w_next_starve = '0;
          end
        end
      end

      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_tcm_ack) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // State registers
  //---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= 1'b0;
      r_starve <= '0;
      r_addr   <= '0;
      r_sel    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_grant  <= w_next_grant;
      r_starve <= w_next_starve;
      if (w_capture) begin
        if (w_pick_dbus) begin
          r_addr  <= i_dbus_addr;
          r_sel   <= i_dbus_sel;
          r_write <= i_dbus_write;
          r_wdata <= i_dbus_data;
        end else begin
          r_addr  <= i_ibus_addr;
          r_sel   <= '1;
          r_write <= 1'b0;
          r_wdata <= '0;
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  // Reset is synchronous, so the state register still holds its old value
  // during the reset cycle; gating with i_reset keeps every control output
  // quiet for that cycle (including an ack that happens to arrive in WAIT).
  assign w_active = !i_reset;
  assign w_issue  = w_active && (r_state == ST_ISSUE);

  assign o_dev_sel  = w_issue;
  assign o_addr     = w_issue ? r_addr  : '0;
  assign o_sel      = w_issue ? r_sel   : '0;
  assign o_write    = w_issue ? r_write : 1'b0;
  assign o_wdata    = w_issue ? r_wdata : '0;

  assign o_ibus_ack = w_active && (r_state == ST_WAIT) && i_tcm_ack && !r_grant;
  assign o_dbus_ack = w_active && (r_state == ST_WAIT) && i_tcm_ack &&  r_grant;

  assign o_busy     = w_active && (r_state != ST_IDLE);
  assign o_rdata    = i_tcm_data;

endmodule

// File: tb/tb_tcm_arbiter.sv
module tb_tcm_arbiter;

  localparam int AW  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic          i_ibus_req;
  logic [AW+1:2] i_ibus_addr;
  logic          o_ibus_ack;
  logic          i_dbus_req;
  logic [AW+1:2] i_dbus_addr;
  logic [3:0]    i_dbus_sel;
  logic          i_dbus_write;
  logic [31:0]   i_dbus_data;
  logic          o_dbus_ack;
  logic [31:0]   o_rdata;
  logic          o_dev_sel;
  logic [AW+1:2] o_addr;
  logic [3:0]    o_sel;
  logic          o_write;
  logic [31:0]   o_wdata;
  logic          i_tcm_ack;
  logic [31:0]   i_tcm_data;
  logic          o_busy;

  tcm_arbiter #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr), .o_ibus_ack(o_ibus_ack),
    .i_dbus_req(i_dbus_req), .i_dbus_addr(i_dbus_addr), .i_dbus_sel(i_dbus_sel),
    .i_dbus_write(i_dbus_write), .i_dbus_data(i_dbus_data), .o_dbus_ack(o_dbus_ack),
    .o_rdata(o_rdata),
    .o_dev_sel(o_dev_sel), .o_addr(o_addr), .o_sel(o_sel), .o_write(o_write),
    .o_wdata(o_wdata), .i_tcm_ack(i_tcm_ack), .i_tcm_data(i_tcm_data),
    .o_busy(o_busy)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_ack_cyc = 0;
  int          stall = 0;
  int          starve = 0;          // reference: dbus wins while ibus waited

  logic [31:0] tcm_mem [256];       // memory as modified by the DUT's bus
  logic [31:0] ref_mem [256];       // memory as the intended transactions leave it

  // TCM responder: sees o_dev_sel, acks 1 + stall cycles later.
  int          pend = 0;
  int          cnt  = 0;
  logic [31:0] rd_hold;
  always @(negedge clk) begin
    i_tcm_ack  = 1'b0;
    i_tcm_data = $urandom;
    if (pend != 0) begin
      if (cnt == 0) begin
        i_tcm_ack  = 1'b1;
        i_tcm_data = rd_hold;
        pend       = 0;
      end else begin
        cnt--;
      end
    end
    if (o_dev_sel) begin
      pend    = 1;
      cnt     = stall;
      rd_hold = tcm_mem[o_addr];
      if (o_write) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (o_sel[b]) tcm_mem[o_addr][8*b +: 8] = o_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  // Arbitration rules applied to the requests seen in an IDLE cycle.
  task automatic ref_idle(output bit any, output bit pick_d);
    if (!i_ibus_req) starve = 0;
    any    = i_ibus_req || i_dbus_req;
    pick_d = i_dbus_req && !(i_ibus_req && starve == LIM);
    if (any) begin
      if (!pick_d)         starve = 0;
      else if (i_ibus_req) starve = (starve < LIM) ? starve + 1 : LIM;
    end
  endtask

  task automatic idle_cycle();
    bit any, pd;
    #1;
    ref_idle(any, pd);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_devsel", 32'(o_dev_sel), 32'd0);
    chk("idle_addr", 32'(o_addr), 32'd0);
    chk("idle_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
  endtask

  // Full access starting in an IDLE cycle whose inputs are already driven.
  task automatic access_cycle(input bit drop_d, output bit won_d, output logic [31:0] got_rd);
    bit          any, pd;
    logic [AW-1:0] ea;
    logic [3:0]  es;
    logic        ew;
    logic [31:0] ed;
    #1;
    ref_idle(any, pd);
    chk("idle_busy", 32'(o_busy), 32'd0);
    ea = pd ? i_dbus_addr : i_ibus_addr;
    es = pd ? i_dbus_sel  : 4'hF;
    ew = pd && i_dbus_write;
    ed = pd ? i_dbus_data : 32'd0;

    next_cycle();
    if (drop_d) i_dbus_req = 1'b0;
    #1;
    chk("iss_devsel", 32'(o_dev_sel), 32'd1);
    chk("iss_addr", 32'(o_addr), 32'(ea));
    chk("iss_sel", 32'(o_sel), 32'(es));
    chk("iss_write", 32'(o_write), 32'(ew));
    chk("iss_wdata", o_wdata, ed);
    chk("iss_busy", 32'(o_busy), 32'd1);
    chk("iss_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);

    for (int unsigned k = 0; k < 32'(stall); k++) begin
      next_cycle();
      #1;
      chk("stall_devsel", 32'(o_dev_sel), 32'd0);
      chk("stall_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
      chk("stall_busy", 32'(o_busy), 32'd1);
    end

    next_cycle();
    #1;
    chk("ack_ibus", 32'(o_ibus_ack), 32'(!pd));
    chk("ack_dbus", 32'(o_dbus_ack), 32'(pd));
    chk("rdata_pass", o_rdata, i_tcm_data);
    if (!ew) chk("rdata_val", o_rdata, ref_mem[ea]);
    else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (es[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
      end
    end
    got_rd       = o_rdata;
    last_ack_cyc = cyc;
    won_d        = pd;
  endtask

  bit          w;
  bit          last_w;
  bit          had_acc;
  logic [31:0] rd;
  logic [31:0] old;
  int          prev_ack;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      tcm_mem[i] = $urandom;
      ref_mem[i] = tcm_mem[i];
    end
    i_reset = 1'b1;
    i_ibus_req = 1'b0; i_ibus_addr = '0;
    i_dbus_req = 1'b0; i_dbus_addr = '0; i_dbus_sel = '0;
    i_dbus_write = 1'b0; i_dbus_data = '0;

    // reset state
    repeat (2) begin
      next_cycle();
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_devsel", 32'(o_dev_sel), 32'd0);
      chk("rst_fields", {o_sel, o_write, 19'd0, o_addr}, 32'd0);
      chk("rst_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
    end
    next_cycle(); i_reset = 1'b0; starve = 0; idle_cycle();

    // ibus read of 0x10
    next_cycle(); i_ibus_req = 1'b1; i_ibus_addr = 8'h10;
    access_cycle(1'b0, w, rd);
    chk("i_only_win", 32'(w), 32'd0);

    // dbus partial write then ibus read-back
    next_cycle(); i_ibus_req = 1'b0;
    old = ref_mem[5];
    i_dbus_req = 1'b1; i_dbus_addr = 8'h05; i_dbus_sel = 4'b0011;
    i_dbus_write = 1'b1; i_dbus_data = 32'hA5A5_1234;
    access_cycle(1'b0, w, rd);
    chk("d_wr_win", 32'(w), 32'd1);
    next_cycle(); i_dbus_req = 1'b0; i_dbus_write = 1'b0;
    i_ibus_req = 1'b1; i_ibus_addr = 8'h05;
    access_cycle(1'b0, w, rd);
    chk("wr_merge", rd, {old[31:16], 16'h1234});

    // both ports continuously: D,D,D,D,I repeating, 3 cycles per access
    next_cycle(); i_ibus_req = 1'b0; idle_cycle();
    next_cycle(); i_ibus_req = 1'b1; i_ibus_addr = 8'h21;
    i_dbus_req = 1'b1; i_dbus_addr = 8'h22; i_dbus_sel = 4'hF;
    for (int unsigned j = 0; j < 10; j++) begin
      if (j != 0) next_cycle();
      prev_ack = last_ack_cyc;
      access_cycle(1'b0, w, rd);
      chk("starve_seq", 32'(w), 32'((j % 5) != 4));
      if (j != 0) chk("ack_spacing", 32'(last_ack_cyc - prev_ack), 32'd3);
    end
    next_cycle(); i_ibus_req = 1'b0; i_dbus_req = 1'b0; idle_cycle();

    // reset during WAIT: TCM ack in the reset cycle, then in the cycle after
    for (int unsigned s = 0; s < 2; s++) begin
      bit any, pd;
      next_cycle(); stall = int'(s); i_ibus_req = 1'b1; i_ibus_addr = 8'h2A;
      #1; ref_idle(any, pd);
      next_cycle(); #1;
      chk("rw_devsel", 32'(o_dev_sel), 32'd1);
      next_cycle(); i_reset = 1'b1; i_ibus_req = 1'b0; #1;
      chk("rw_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
      chk("rw_busy", 32'(o_busy), 32'd0);
      chk("rw_devsel0", 32'(o_dev_sel), 32'd0);
      next_cycle(); i_reset = 1'b0; starve = 0; #1;
      chk("rw_post_acks", 32'({o_ibus_ack, o_dbus_ack}), 32'd0);
      chk("rw_post_busy", 32'(o_busy), 32'd0);
      stall = 0;
      next_cycle(); idle_cycle();
      next_cycle(); i_ibus_req = 1'b1; i_ibus_addr = 8'h2B;
      access_cycle(1'b0, w, rd);
      chk("rw_fresh_win", 32'(w), 32'd0);
      next_cycle(); i_ibus_req = 1'b0; idle_cycle();
    end

    // dbus request dropped during ISSUE
    next_cycle(); i_dbus_req = 1'b1; i_dbus_addr = 8'h33; i_dbus_sel = 4'hF; i_dbus_write = 1'b0;
    access_cycle(1'b1, w, rd);
    next_cycle(); idle_cycle();

    // TCM stalls three extra cycles
    stall = 3;
    next_cycle(); i_ibus_req = 1'b1; i_ibus_addr = 8'h40;
    access_cycle(1'b0, w, rd);
    stall = 0;
    next_cycle(); i_ibus_req = 1'b0; idle_cycle();

    // randomized traffic
    had_acc = 1'b0;
    last_w  = 1'b0;
    for (int unsigned t = 0; t < 300; t++) begin
      next_cycle();
      if (had_acc) begin
        if (last_w) i_dbus_req = 1'b0;
        else        i_ibus_req = 1'b0;
      end
      if (!i_ibus_req && $urandom_range(0, 2) != 0) begin
        i_ibus_req  = 1'b1;
        i_ibus_addr = 8'($urandom_range(0, 15));
      end
      if (!i_dbus_req && $urandom_range(0, 2) != 0) begin
        i_dbus_req   = 1'b1;
        i_dbus_addr  = 8'($urandom_range(0, 15));
        i_dbus_sel   = 4'($urandom);
        i_dbus_write = 1'($urandom);
        i_dbus_data  = $urandom;
      end
      stall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (i_ibus_req || i_dbus_req) begin
        access_cycle(1'b0, w, rd);
        last_w  = w;
        had_acc = 1'b1;
      end else begin
        idle_cycle();
        had_acc = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
